// File: rtl/cpu_defs.sv
// Shared CPU-side definitions: arbiter FSM states, bus owner and access size codes.
package cpu_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_DATA = 1'b0,
    OWN_INST = 1'b1
  } arb_owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive inst losses to the data port; sat tells the arbiter that
// inst must win the next contested grant.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [3:0] cnt;

  // Loss counter: clear wins over increment, holds at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt != 4'(STARVE_MAX))) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign sat = (cnt == 4'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (inst/data) to one downstream memory arbiter with a single
// outstanding transaction. Data has priority; a starvation counter forces an
// inst grant after STARVE_MAX consecutive contested losses.
module mem_arbiter
  import cpu_defs::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        busy
);

  arb_state_t state;
  arb_owner_t owner;
  logic       grant_d;
  logic       grant_i;
  logic       starve_sat;
  logic       done;

  // Grant decision, only meaningful in IDLE; held off while reset is active.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if ((state == ST_IDLE) && !rst) begin
      if (d_req && !(starve_sat && i_req)) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (grant_d && i_req),
    .clr (grant_i),
    .sat (starve_sat)
  );

  // Transaction FSM with latched request fields and registered req/busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= OWN_DATA;
      wr    <= 1'b0;
      size  <= 2'd0;
      addr  <= 32'd0;
      wdata <= 32'd0;
      req   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            owner <= OWN_DATA;
            wr    <= d_wr;
            size  <= d_size;
            addr  <= d_addr;
            wdata <= d_wdata;
            req   <= 1'b1;
            busy  <= 1'b1;
            state <= ST_ADDR;
          end else if (grant_i) begin
            owner <= OWN_INST;
            wr    <= 1'b0;
            size  <= SIZE_WORD;
            addr  <= i_addr;
            wdata <= 32'd0;
            req   <= 1'b1;
            busy  <= 1'b1;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (addr_ok) begin
            req   <= 1'b0;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_ok) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          req   <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Upstream handshakes: accept only in IDLE, complete only to the owner.
  assign done      = (state == ST_DATA) && data_ok;
  assign i_addr_ok = grant_i;
  assign d_addr_ok = grant_d;
  assign i_data_ok = done && (owner == OWN_INST);
  assign d_data_ok = done && (owner == OWN_DATA);
  assign i_rdata   = rdata;
  assign d_rdata   = rdata;

endmodule
